// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//
// MM:SS countdown timer held as four BCD digits. A preset is loaded, clamped
// to a legal BCD time (max 99:59), and counted down by one second on each
// one-cycle-wide tick while running. Start / pause / resume are pulse
// controls. On the tick that reaches 00:00 the timer enters DONE and raises
// a single-cycle timeout pulse.
//
// Optional feature macro: COUNTDOWN_WARN_EN
//   defined   : o_warn is a registered low-time flag, high while RUN/PAUSE
//               and 00:00 < count <= 00:10.
//   undefined : o_warn is tied to 0 and no warn logic exists.
//
// Ports
//   i_clk                     system clock, all state changes on posedge
//   i_rst                     synchronous active-high reset
//   i_tick                    one-second enable, one cycle wide
//   i_load                    capture preset digits (IDLE / PAUSE / DONE)
//   i_start                   start or resume counting
//   i_pause                   suspend counting
//   i_preset_m1..i_preset_s0  preset digits, BCD (out-of-range values clamp)
//   o_dig_m1..o_dig_s0        remaining time, BCD, registered
//   o_state                   IDLE=0, RUN=1, PAUSE=2, DONE=3
//   o_timeout                 one-cycle pulse on the first DONE cycle
//   o_warn                    low-time warning (see macro above)
// ---------------------------------------------------------------------------
module countdown_timer (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_load,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic [3:0] i_preset_m1,
    input  logic [3:0] i_preset_m0,
    input  logic [3:0] i_preset_s1,
    input  logic [3:0] i_preset_s0,
    output logic [3:0] o_dig_m1,
    output logic [3:0] o_dig_m0,
    output logic [3:0] o_dig_s1,
    output logic [3:0] o_dig_s0,
    output logic [1:0] o_state,
    output logic       o_timeout,
    output logic       o_warn
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e     r_state;
    state_e     w_state_next;

    logic [3:0] r_m1, r_m0, r_s1, r_s0;
    logic [3:0] w_m1_next, w_m0_next, w_s1_next, w_s0_next;
    logic       r_timeout;
    logic       w_timeout_next;

    // Clamped preset digits
    logic [3:0] w_ld_m1, w_ld_m0, w_ld_s1, w_ld_s0;

    // Decremented count and the borrow chain that produces it
    logic [3:0] w_dec_m1, w_dec_m0, w_dec_s1, w_dec_s0;
    logic       w_brw_s1, w_brw_m0, w_brw_m1;

    logic       w_count_zero;
    logic       w_count_one;
    logic       w_run_tick;
    logic       w_do_load;

    // ------------------------------------------------------------------
    // Preset clamp: tens-of-seconds saturates at 5, other digits at 9.
    // ------------------------------------------------------------------
    always_comb begin
        w_ld_m1 = (i_preset_m1 > 4'd9) ? 4'd9 : i_preset_m1;
        w_ld_m0 = (i_preset_m0 > 4'd9) ? 4'd9 : i_preset_m0;
        w_ld_s1 = (i_preset_s1 > 4'd5) ? 4'd5 : i_preset_s1;
        w_ld_s0 = (i_preset_s0 > 4'd9) ? 4'd9 : i_preset_s0;
    end

    // ------------------------------------------------------------------
    // BCD decrement by one second. m1 has no wrap: RUN is never entered
    // at 00:00, so a borrow out of m1 cannot occur.
    // ------------------------------------------------------------------
    always_comb begin
        w_brw_s1 = (r_s0 == 4'd0);
        w_dec_s0 = w_brw_s1 ? 4'd9 : (r_s0 - 4'd1);

        w_brw_m0 = w_brw_s1 && (r_s1 == 4'd0);
        w_dec_s1 = !w_brw_s1 ? r_s1 : ((r_s1 == 4'd0) ? 4'd5 : (r_s1 - 4'd1));

        w_brw_m1 = w_brw_m0 && (r_m0 == 4'd0);
        w_dec_m0 = !w_brw_m0 ? r_m0 : ((r_m0 == 4'd0) ? 4'd9 : (r_m0 - 4'd1));

        w_dec_m1 = w_brw_m1 ? (r_m1 - 4'd1) : r_m1;
    end

    always_comb begin
        w_count_zero = (r_m1 == 4'd0) && (r_m0 == 4'd0) && (r_s1 == 4'd0) && (r_s0 == 4'd0);
        w_count_one  = (r_m1 == 4'd0) && (r_m0 == 4'd0) && (r_s1 == 4'd0) && (r_s0 == 4'd1);
        w_run_tick   = (r_state == StRun) && i_tick;
        // Load is honoured everywhere except RUN.
        w_do_load    = i_load && (r_state != StRun);
    end

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                // Load wins over start; start at 00:00 is ignored.
                if (!i_load && i_start && !w_count_zero) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                // Expiry beats a simultaneous pause.
                if (i_tick && w_count_one) begin
                    w_state_next = StDone;
                end else if (i_pause) begin
                    w_state_next = StPause;
                end
            end
            StPause: begin
                if (i_load) begin
                    w_state_next = StIdle;
                end else if (i_start && !i_pause) begin
                    w_state_next = StRun;
                end
            end
            StDone: begin
                if (i_load) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: next values of the registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_m1_next = r_m1;
        w_m0_next = r_m0;
        w_s1_next = r_s1;
        w_s0_next = r_s0;
        if (w_do_load) begin
            w_m1_next = w_ld_m1;
            w_m0_next = w_ld_m0;
            w_s1_next = w_ld_s1;
            w_s0_next = w_ld_s0;
        end else if (w_run_tick) begin
            w_m1_next = w_dec_m1;
            w_m0_next = w_dec_m0;
            w_s1_next = w_dec_s1;
            w_s0_next = w_dec_s0;
        end
        // Pulse only on entry into DONE, not while it persists.
        w_timeout_next = (w_state_next == StDone) && (r_state != StDone);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_m1      <= 4'd0;
            r_m0      <= 4'd0;
            r_s1      <= 4'd0;
            r_s0      <= 4'd0;
            r_timeout <= 1'b0;
        end else begin
            r_m1      <= w_m1_next;
            r_m0      <= w_m0_next;
            r_s1      <= w_s1_next;
            r_s0      <= w_s0_next;
            r_timeout <= w_timeout_next;
        end
    end

    // ------------------------------------------------------------------
    // Low-time warning
    // ------------------------------------------------------------------
`ifdef COUNTDOWN_WARN_EN
    logic w_next_low;
    logic w_warn_next;
    logic r_warn;

    // 00:01 .. 00:10 on the count that will be registered this edge.
    always_comb begin
        w_next_low  = (w_m1_next == 4'd0) && (w_m0_next == 4'd0) &&
                      (((w_s1_next == 4'd0) && (w_s0_next != 4'd0)) ||
                       ((w_s1_next == 4'd1) && (w_s0_next == 4'd0)));
        w_warn_next = ((w_state_next == StRun) || (w_state_next == StPause)) && w_next_low;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_warn <= 1'b0;
        end else begin
            r_warn <= w_warn_next;
        end
    end

    assign o_warn = r_warn;
`else
    assign o_warn = 1'b0;
`endif

    assign o_dig_m1  = r_m1;
    assign o_dig_m0  = r_m0;
    assign o_dig_s1  = r_s1;
    assign o_dig_s0  = r_s0;
    assign o_state   = r_state;
    assign o_timeout = r_timeout;

endmodule
